dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: 0 = core MEM stage, 1 = DMA/debug port.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/rr_arb2.sv | 20 ++
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory arbiter
package dmem_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, last winner loses the next tie
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);
  logic last_q, last_d;
  // on contention favour the requester that did not win last; otherwise grant whoever asks
  always_comb begin
    grant  = (valid == 2'b11) ? (last_q ? 2'b01 : 2'b10) : valid;
    last_d = (en && |valid) ? grant[1] : last_q;
  end
  // last winner starts at 1 so the first tie goes to requester 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 1'b1;
    else      last_q <= last_d;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between core and DMA, with RMW for sub-word stores
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0][1:0]        req_size,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             resp_valid,
  output logic                   resp_err,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic [ADDR_W-1:0]      mem_A,
  output logic [DATA_W-1:0]      mem_WD,
  output logic                   mem_WE,
  input  logic [DATA_W-1:0]      mem_RD
);
  state_t              state_q, state_d;
  logic                id_q, id_d, we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, mem_a_q, mem_a_d, s_addr;
  logic [DATA_W-1:0]   wdata_q, wdata_d, mem_wd_q, mem_wd_d, rdata_q, rdata_d, merged;
  logic                mem_we_q, mem_we_d, err_q, err_d;
  logic [1:0]          rv_q, rv_d, grant, s_size;
  logic                sel, idle, acc, s_err;

  assign idle = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (req_valid),
    .en    (idle),
    .grant (grant)
  );

  // winner selection, accept-time legality check and store-lane merge
  always_comb begin
    sel    = grant[1];
    acc    = idle && |grant;
    s_addr = req_addr[sel];
    s_size = req_size[sel];
    s_err  = (s_size == SIZE_X) || (s_size == SIZE_H && s_addr[0]) ||
             (s_size == SIZE_W && s_addr[1:0] != 2'b00) ||
             (s_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS));
    merged = mem_RD;
    if (size_q == SIZE_B) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                  merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    req_ready = (idle && rst) ? grant : 2'b00;
  end

  // transaction sequencing; every output is registered on the way into the state that shows it
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mem_a_d  = mem_a_q;
    mem_wd_d = mem_wd_q;
    mem_we_d = 1'b0;
    rv_d     = 2'b00;
    err_d    = 1'b0;
    rdata_d  = '0;
    case (state_q)
      ST_IDLE: if (acc) begin
        id_d    = sel;
        we_d    = req_we[sel];
        size_d  = s_size;
        addr_d  = s_addr;
        wdata_d = req_wdata[sel];
        if (s_err) begin
          state_d = ST_RESP;
          rv_d    = {sel, ~sel};
          err_d   = 1'b1;
        end else begin
          state_d  = ST_ACCESS;
          mem_a_d  = {s_addr[ADDR_W-1:2], 2'b00};
          mem_we_d = req_we[sel] && s_size == SIZE_W;
          mem_wd_d = (req_we[sel] && s_size == SIZE_W) ? req_wdata[sel] : mem_wd_q;
        end
      end
      ST_ACCESS: if (we_q && size_q != SIZE_W) begin
        state_d  = ST_MERGE;
        mem_we_d = 1'b1;
        mem_wd_d = merged;
      end else begin
        state_d = ST_RESP;
        rv_d    = {id_q, ~id_q};
        rdata_d = we_q ? '0 : mem_RD;
      end
      ST_MERGE: begin
        state_d = ST_RESP;
        rv_d    = {id_q, ~id_q};
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and registered outputs; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_a_q  <= '0;
      mem_wd_q <= '0;
      mem_we_q <= 1'b0;
      rv_q     <= 2'b00;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mem_a_q  <= mem_a_d;
      mem_wd_q <= mem_wd_d;
      mem_we_q <= mem_we_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign resp_valid = rv_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign mem_A      = mem_a_q;
  assign mem_WD     = mem_wd_q;
  assign mem_WE     = mem_we_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic against a transaction-level reference model
module tb_dmem_arbiter;
  import dmem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] req_valid = '0, req_we = '0, req_ready, resp_valid;
  logic [1:0][1:0] req_size = '0;
  logic [1:0][31:0] req_addr = '0, req_wdata = '0;
  logic resp_err, mem_WE;
  logic [31:0] resp_rdata, mem_A, mem_WD, mem_RD;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  bit init_req = 1'b0;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_A(mem_A), .mem_WD(mem_WD),
    .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  // behavioural data memory: combinational read, clocked write
  assign mem_RD = mem[mem_A[11:2]];
  always @(posedge clk) begin
    if (init_req) for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
    else if (mem_WE) mem[mem_A[11:2]] <= mem_WD;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: one transaction at a time, timed from its accept cycle
  bit busy = 1'b0, m_last = 1'b1, win, t_id, t_we, t_err;
  int k, lat, wk, sh;
  logic [1:0] t_size, exp_ready;
  logic [31:0] t_addr, t_wdata, t_rd, old_w, new_w;
  int acc_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      busy = 1'b0;
      m_last = 1'b1;
      check("rst_ready", req_ready, 0);
      check("rst_resp", resp_valid, 0);
      check("rst_err", resp_err, 0);
      check("rst_rdata", resp_rdata, 0);
      check("rst_we", mem_WE, 0);
    end else if (!busy) begin
      win = (req_valid == 2'b11) ? !m_last : req_valid[1];
      exp_ready = (req_valid == 2'b00) ? 2'b00 : (win ? 2'b10 : 2'b01);
      check("ready", req_ready, exp_ready);
      check("idle_resp", resp_valid, 0);
      check("idle_we", mem_WE, 0);
      if (req_valid != 2'b00) begin
        busy = 1'b1;
        k = 0;
        m_last = win;
        acc_log.push_back(win);
        t_id = win;
        t_we = req_we[win];
        t_size = req_size[win];
        t_addr = req_addr[win];
        t_wdata = req_wdata[win];
        t_err = (t_size == 2'd3) || (t_addr % (1 << t_size) != 0) || (t_addr / 4 >= 1024);
        lat = t_err ? 1 : (t_we && t_size != 2'd2) ? 3 : 2;
        t_rd = t_err ? 32'h0 : ref_mem[t_addr[11:2]];
      end
    end else begin
      k++;
      wk = (t_err || !t_we) ? -1 : (t_size == 2'd2) ? 1 : 2;
      check("busy_ready", req_ready, 0);
      check("mem_we", mem_WE, k == wk);
      if (k == wk) begin
        old_w = ref_mem[t_addr[11:2]];
        sh = 8 * (t_addr % 4);
        new_w = (t_size == 2'd2) ? t_wdata :
                (t_size == 2'd0) ? ((old_w & ~(32'hFF << sh)) | ((t_wdata & 32'hFF) << sh)) :
                                   ((old_w & ~(32'hFFFF << sh)) | ((t_wdata & 32'hFFFF) << sh));
        check("mem_A", mem_A, t_addr & ~32'h3);
        check("mem_WD", mem_WD, new_w);
        ref_mem[t_addr[11:2]] = new_w;
      end
      if (k == lat) begin
        check("resp_valid", resp_valid, t_id ? 2'b10 : 2'b01);
        check("resp_err", resp_err, t_err);
        check("resp_rdata", resp_rdata, (t_err || t_we) ? 32'h0 : t_rd);
        busy = 1'b0;
      end else check("resp_quiet", resp_valid, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // present a request, wait (bounded) for its handshake, then withdraw valid
  task automatic send(input int r, input bit we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    req_we[r] = we;
    req_size[r] = sz;
    req_addr[r] = a;
    req_wdata[r] = d;
    req_valid[r] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready[r];
    end
    check("handshake", ok, 1);
    tick(1);
    req_valid[r] = 1'b0;
  endtask

  task automatic rand_payload(input int r);
    logic [1:0] sz;
    logic [9:0] off;
    int idx;
    sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    idx = ($urandom_range(0, 9) == 0) ? $urandom_range(1020, 1027) : $urandom_range(0, 31);
    off = 10'($urandom_range(0, 3));
    if ($urandom_range(0, 3) != 0) off = (sz == 2'd2) ? 10'd0 : (sz == 2'd1) ? (off & 10'd2) : off;
    req_we[r] = 1'($urandom_range(0, 1));
    req_size[r] = sz;
    req_addr[r] = 32'(idx * 4) + 32'(off);
    req_wdata[r] = $urandom;
  endtask

  logic [31:0] saved;
  logic [1:0] acc;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'hDEADBEEF;
    ref_mem[8] = 32'h11223344;
    init_req = 1'b1;
    req_valid = 2'b11;
    tick(1);
    init_req = 1'b0;
    tick(2);
    check("rst_mem_A", mem_A, 0);
    check("rst_mem_WD", mem_WD, 0);
    req_valid = 2'b00;
    rst = 1'b1;
    tick(1);
    send(0, 1'b0, SIZE_W, 32'h10, 32'h0);
    tick(3);
    send(1, 1'b1, SIZE_B, 32'h21, 32'hAB);
    tick(4);
    check("byte_store", mem[8], 32'h1122AB44);
    rst = 1'b0;
    acc_log.delete();
    req_we = 2'b00;
    req_size = {SIZE_W, SIZE_W};
    req_addr = {32'h20, 32'h10};
    req_valid = 2'b11;
    tick(1);
    rst = 1'b1;
    for (int i = 0; i < 40 && acc_log.size() < 4; i++) @(negedge clk);
    tick(1);
    req_valid = 2'b00;
    check("fair_count", acc_log.size() >= 4, 1);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) check($sformatf("grant%0d", i), acc_log[i], i % 2);
    tick(4);
    send(0, 1'b0, SIZE_W, 32'h1002, 32'h0);
    tick(2);
    send(0, 1'b0, SIZE_W, 32'h1000, 32'h0);
    tick(2);
    send(0, 1'b1, SIZE_B, 32'hFFF, 32'h5A);
    tick(4);
    send(1, 1'b0, SIZE_X, 32'h8, 32'h0);
    tick(2);
    saved = mem[16];
    send(0, 1'b1, SIZE_H, 32'h42, 32'hBEEF);
    tick(1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(3);
    check("rmw_abort", mem[16], saved);
    req_we[1] = 1'b1;
    req_size[1] = SIZE_H;
    req_addr[1] = 32'h32;
    req_wdata[1] = 32'h1234;
    req_valid[1] = 1'b1;
    @(negedge clk);
    tick(1);
    req_valid[1] = 1'b0;
    req_we[0] = 1'b0;
    req_size[0] = SIZE_W;
    req_addr[0] = 32'h10;
    req_valid[0] = 1'b1;
    tick(1);
    req_valid[0] = 1'b0;
    tick(5);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick(1);
      for (int r = 0; r < 2; r++) begin
        if (req_valid[r] && !acc[r]) begin
          if ($urandom_range(0, 15) == 0) req_valid[r] = 1'b0;
        end else begin
          req_valid[r] = 1'($urandom_range(0, 1));
          if (req_valid[r]) rand_payload(r);
        end
      end
    end
    req_valid = 2'b00;
    tick(6);
    for (int i = 0; i < 1024; i++) check($sformatf("mem%0d", i), mem[i], ref_mem[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
